// File: rtl/extra1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : extra1_pkg
//  Description : Shared types and constants for the two-requester scheduler
//                that fronts the extra1 compute datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package extra1_pkg;

    // Default operand and result widths of the shared datapath
    localparam int W_IN_DEF = 32;
    localparam int W_Q_DEF  = 36;

    // Requester identifiers carried in the tag pipeline
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // One in-flight issue: occupancy bit plus the issuing requester
    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    // The requester that is not 'id' (two-way round robin)
    function automatic logic other_req(input logic id);
        return (id == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/extra1_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : extra1_rr_arb
//  Description : Two-way round-robin arbiter. Grants are combinational from
//                the valids and the last-granted pointer; the pointer moves
//                only when a grant is given. Requester 0 has priority after
//                reset, and no grant is given while reset is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module extra1_rr_arb
    import extra1_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_grant0,
    output logic o_grant1
);

    // Last requester granted; resetting to REQ1 gives REQ0 first priority
    logic r_last;
    logic w_grant0;
    logic w_grant1;

    // Lone requester wins; on contention the one not granted last wins
    always_comb begin
        w_grant0 = rst_n & i_valid0 & (~i_valid1 | (r_last == REQ1));
        w_grant1 = rst_n & i_valid1 & (~i_valid0 | (r_last == REQ0));
    end

    assign o_grant0 = w_grant0;
    assign o_grant1 = w_grant1;

    // Pointer follows the winner, and only when a transfer happens
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= REQ1;
        end else if (w_grant0 || w_grant1) begin
            r_last <= w_grant1 ? REQ1 : other_req(REQ1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/extra1_sched.sv
`default_nettype none
// ============================================================================
//  Module      : extra1_sched
//  Description : Shares one fixed-latency datapath between two operand
//                requesters. Arbitrates round-robin, issues one operand
//                triple per cycle, tracks each issue with a requester tag
//                over LAT+1 stages and steers returning results back to
//                the issuing requester. Flags unmatched results sticky.
//  Revision    : 1.0 - initial release
// ============================================================================
module extra1_sched
    import extra1_pkg::*;
#(
    parameter int LAT  = 4,
    parameter int W_IN = W_IN_DEF,
    parameter int W_Q  = W_Q_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    // requester 0
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [W_IN-1:0] req0_a,
    input  logic [W_IN-1:0] req0_b,
    input  logic [W_IN-1:0] req0_c,
    // requester 1
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [W_IN-1:0] req1_a,
    input  logic [W_IN-1:0] req1_b,
    input  logic [W_IN-1:0] req1_c,
    // datapath issue side
    output logic            dp_valid,
    output logic [W_IN-1:0] dp_a,
    output logic [W_IN-1:0] dp_b,
    output logic [W_IN-1:0] dp_c,
    // datapath result side
    input  logic            dp_q_valid,
    input  logic [W_Q-1:0]  dp_q,
    // steered results and status
    output logic            res0_valid,
    output logic            res1_valid,
    output logic [W_Q-1:0]  res_q,
    output logic            busy,
    output logic            err
);

    // In-flight count spans 0..LAT+1
    localparam int c_CNT_W = $clog2(LAT + 2);

    logic               w_grant0;
    logic               w_grant1;
    logic               w_xfer;
    logic               w_win_id;
    tag_t               w_new_tag;
    tag_t               w_tail;
    logic               w_tagged_res;
    tag_t [LAT:0]       r_tag;
    logic [c_CNT_W-1:0] r_cnt;

    extra1_rr_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // A grant is a transfer; at most one grant is ever high
    always_comb begin
        w_xfer        = w_grant0 | w_grant1;
        w_win_id      = w_grant1 ? REQ1 : REQ0;
        w_new_tag.vld = w_xfer;
        w_new_tag.id  = w_win_id;
        w_tail        = r_tag[LAT];
        w_tagged_res  = dp_q_valid & w_tail.vld;
    end

    // Issue register: strobe for one cycle, operands hold between issues
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_valid <= 1'b0;
            dp_a     <= '0;
            dp_b     <= '0;
            dp_c     <= '0;
        end else begin
            dp_valid <= w_xfer;
            if (w_xfer) begin
                dp_a <= w_grant1 ? req1_a : req0_a;
                dp_b <= w_grant1 ? req1_b : req0_b;
                dp_c <= w_grant1 ? req1_c : req0_c;
            end
        end
    end

    // Tag shift register; the tail lines up with the matching dp_q_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else begin
            r_tag <= {r_tag[LAT-1:0], w_new_tag};
        end
    end

    // In-flight counter; a tail tag leaves flight whether matched or dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_xfer, w_tail.vld})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign busy = (r_cnt != '0);

    // Result steering by tail tag; any tag/strobe disagreement is sticky err
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res_q      <= '0;
            err        <= 1'b0;
        end else begin
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            if (w_tagged_res) begin
                res_q      <= dp_q;
                res0_valid <= (w_tail.id == REQ0);
                res1_valid <= (w_tail.id == REQ1);
            end else if (dp_q_valid || w_tail.vld) begin
                err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
